// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//
// Contents:
//   rx_state_t           receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT default bit period in clock cycles
//   DATA_BITS            payload bits per frame (8N1)
//   half_bit()           cycles from a detected start edge to mid-start-bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DATA_BITS            = 8;

  // Mid-bit offset. Truncating division keeps the sample point at or just
  // before the true centre for odd bit periods.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for asynchronous inputs.
//
// Parameters:
//   RESET_VAL  value both flops take during reset (use the input's idle level)
// Ports:
//   clk_i   input  1  destination clock
//   srst_i  input  1  synchronous active-high reset
//   d_i     input  1  asynchronous input
//   q_o     output 1  synchronised output, lags d_i by two clock edges
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Deserialises the RX line into bytes and holds
// the last good byte until the consumer acknowledges it.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
// Ports:
//   CLK        input  1  system clock, posedge
//   reset      input  1  synchronous active-high reset
//   Rx         input  1  asynchronous serial line, idle high
//   rd_ack     input  1  consumer took out_data; clears out_valid
//   out_data   output 8  last good received byte
//   out_valid  output 1  level: unread byte held in out_data
//   rx_busy    output 1  frame in progress (state != IDLE)
//   frame_err  output 1  one-cycle pulse when the stop bit is sampled low
//   overrun    output 1  sticky: byte delivered while previous one unread
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 Rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Synchronised line; idle-high reset value so reset never looks like a
  // start bit.
  logic rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (CLK),
    .srst_i (reset),
    .d_i    (Rx),
    .q_o    (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;
  logic                 ovr_q,   ovr_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    // Acknowledge clears the held byte; a delivery below in the same cycle
    // overrides this, so the new byte is never lost.
    if (rd_ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid-start means a glitch, not a frame.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rd_ack) begin
              ovr_d = 1'b1;
            end
            // Returning to IDLE at mid-stop leaves half a bit of margin to
            // catch a start bit that immediately follows.
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        // A held-low (break) line must go high before a new start edge
        // can be recognised.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 87 clocks/bit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 87;

  logic       CLK;
  logic       reset;
  logic       Rx;
  logic       rd_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .Rx        (Rx),
    .rd_ack    (rd_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int valid_rise_cyc = -1;
  int busy_fall_cyc  = -1;
  int busy_run       = 0;
  int last_busy_run  = 0;
  int ferr_cnt       = 0;
  int ferr_run       = 0;
  int ferr_max       = 0;
  logic [7:0] got[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // Output monitor: deliveries, frame_err pulses, rx_busy run lengths.
  initial begin
    logic       prev_valid;
    logic [7:0] prev_data;
    logic       prev_busy;
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    prev_busy  = 1'b0;
    forever begin
      @(negedge CLK);
      if (out_valid === 1'b1 && (!prev_valid || out_data !== prev_data)) begin
        got.push_back(out_data);
        valid_rise_cyc = cyc;
      end
      prev_valid = (out_valid === 1'b1);
      prev_data  = out_data;
      if (frame_err === 1'b1) begin
        ferr_cnt++;
        ferr_run++;
        if (ferr_run > ferr_max) ferr_max = ferr_run;
      end else begin
        ferr_run = 0;
      end
      if (rx_busy === 1'b1) begin
        busy_run++;
      end else if (prev_busy) begin
        last_busy_run = busy_run;
        busy_fall_cyc = cyc;
        busy_run      = 0;
      end
      prev_busy = (rx_busy === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Transmitter model: start, 8 data bits LSB first, stop. Called on a
  // falling edge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    Rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      wait_cycles(CPB);
    end
    Rx = stop_bit;
    wait_cycles(CPB);
  endtask

  task automatic consume();
    int w;
    w = 0;
    while (out_valid !== 1'b1 && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    check("consume_wait", 32'(out_valid), 1);
    rd_ack = 1'b1;
    @(negedge CLK);
    rd_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    int s;
    int f0;

    reset  = 1'b1;
    Rx     = 1'b1;
    rd_ack = 1'b0;
    wait_cycles(3);

    // Reset state
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_rx_busy",   32'(rx_busy),   0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun",   32'(overrun),   0);
    reset = 1'b0;
    wait_cycles(10);

    // 1: 0xA5 frame, exact latency 2 + 43 + 783 + 1 = 829
    got.delete();
    s  = cyc;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_cycles(20);
    check("t1_latency",   32'(valid_rise_cyc - s), 829);
    check("t1_busy_fall", 32'(busy_fall_cyc - s),  829);
    check("t1_out_data",  32'(out_data),  'hA5);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_frame_err", 32'(ferr_cnt - f0), 0);
    check("t1_ndeliv",    32'(got.size()), 1);
    rd_ack = 1'b1;
    @(negedge CLK);
    rd_ack = 1'b0;
    check("t1_ack_clears", 32'(out_valid), 0);
    check("t1_ack_keeps_data", 32'(out_data), 'hA5);
    // rd_ack with nothing held is harmless
    rd_ack = 1'b1;
    @(negedge CLK);
    rd_ack = 1'b0;
    check("t1_idle_ack", 32'(out_valid), 0);

    // 2: back-to-back 0xAA, 0x55 with acknowledgements
    got.delete();
    fork
      begin
        send_frame(8'hAA, 1'b1);
        send_frame(8'h55, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) consume();
      end
    join
    wait_cycles(10);
    check("t2_ndeliv",  32'(got.size()), 2);
    check("t2_first",   32'(got[0]), 'hAA);
    check("t2_second",  32'(got[1]), 'h55);
    check("t2_overrun", 32'(overrun), 0);
    check("t2_valid",   32'(out_valid), 0);

    // 3: 20-cycle glitch
    got.delete();
    f0 = ferr_cnt;
    Rx = 1'b0;
    wait_cycles(20);
    Rx = 1'b1;
    wait_cycles(100);
    check("t3_busy_seen",  32'(last_busy_run > 0), 1);
    check("t3_busy_le_44", 32'(last_busy_run <= 44), 1);
    check("t3_busy_now",   32'(rx_busy), 0);
    check("t3_valid",      32'(out_valid), 0);
    check("t3_ndeliv",     32'(got.size()), 0);
    check("t3_frame_err",  32'(ferr_cnt - f0), 0);

    // 4: bad stop bit then held-low line
    got.delete();
    f0       = ferr_cnt;
    ferr_max = 0;
    send_frame(8'h3C, 1'b0);
    wait_cycles(300);
    check("t4_ferr_count", 32'(ferr_cnt - f0), 1);
    check("t4_ferr_width", 32'(ferr_max), 1);
    check("t4_valid",      32'(out_valid), 0);
    check("t4_data_kept",  32'(out_data), 'h55);
    check("t4_ndeliv",     32'(got.size()), 0);
    check("t4_busy_low",   32'(rx_busy), 1);
    Rx = 1'b1;
    wait_cycles(5);
    check("t4_busy_released", 32'(rx_busy), 0);
    wait_cycles(20);
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    check("t4_ndeliv2", 32'(got.size()), 1);
    check("t4_recover", 32'(got[0]), 'h81);
    check("t4_valid2",  32'(out_valid), 1);
    consume();

    // 5a: overrun when second byte lands unread
    got.delete();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(50);
    check("t5a_data",    32'(out_data), 'h22);
    check("t5a_valid",   32'(out_valid), 1);
    check("t5a_overrun", 32'(overrun), 1);
    check("t5a_ndeliv",  32'(got.size()), 2);
    wait_cycles(20);
    check("t5a_sticky",  32'(overrun), 1);

    // 5b: rd_ack coincident with the second delivery
    pulse_reset();
    check("t5b_rst_overrun", 32'(overrun), 0);
    wait_cycles(10);
    send_frame(8'h11, 1'b1);
    s = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_cycles(828);
        rd_ack = 1'b1;
        @(negedge CLK);
        rd_ack = 1'b0;
      end
    join
    wait_cycles(50);
    check("t5b_data",    32'(out_data), 'h22);
    check("t5b_valid",   32'(out_valid), 1);
    check("t5b_overrun", 32'(overrun), 0);

    // 6: reset during bit 4 of 0xF0, then clean 0x0F
    got.delete();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_cycles(CPB + 4 * CPB + 40);
        pulse_reset();
        check("t6_rst_data",    32'(out_data),  0);
        check("t6_rst_valid",   32'(out_valid), 0);
        check("t6_rst_busy",    32'(rx_busy),   0);
        check("t6_rst_ferr",    32'(frame_err), 0);
        check("t6_rst_overrun", 32'(overrun),   0);
      end
    join
    Rx = 1'b1;
    wait_cycles(20);
    check("t6_no_partial", 32'(got.size()), 0);
    send_frame(8'h0F, 1'b1);
    wait_cycles(50);
    check("t6_ndeliv", 32'(got.size()), 1);
    check("t6_data",   32'(got[0]), 'h0F);
    check("t6_valid",  32'(out_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side UART: deserialises 8N1 frames from the serial line into bytes for the core.
- Pairs with the existing UART transmitter at the same bit timing, so a Tx→Rx loopback round-trips bytes.
- Sits between the board RX pin and the bus/loader logic; holds one received byte until the consumer acknowledges it.

Parameters:
- CLKS_PER_BIT, 87, CLK cycles per serial bit (must be ≥ 4).
- HALF_BIT, CLKS_PER_BIT/2, cycles from detected start edge to mid-start sample (derived, not overridden).

Ports:
- CLK       input   1  system clock; all logic on posedge.
- reset     input   1  synchronous, active-high reset.
- Rx        input   1  asynchronous serial line, idle high.
- rd_ack    input   1  consumer has taken out_data; clears out_valid.
- out_data  output  8  last good received byte, LSB first on the wire.
- out_valid output  1  level: unread byte held in out_data.
- rx_busy   output  1  high while a frame is in progress (state ≠ IDLE).
- frame_err output  1  one-cycle pulse: stop bit sampled low.
- overrun   output  1  sticky: a byte completed while out_valid was still high; cleared by reset only.

Behaviour:
- Rx passes through a 2-FF synchroniser (reset value 1) before any use. Every "Rx" below means the synchronised signal, which lags the pin by 2 cycles.
- Reset values: out_data = 0, out_valid = 0, rx_busy = 0, frame_err = 0, overrun = 0, state = IDLE, counters = 0.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is delivered.
- Single counter cnt and bit index idx[2:0].
- IDLE:
  - Rx = 0 → START with cnt = 0.
  - Otherwise stay.
- START:
  - cnt counts to HALF_BIT−1.
  - At that point, Rx = 1 (glitch) → IDLE with no outputs.
  - Rx = 0 → DATA with cnt = 0, idx = 0.
- DATA:
  - cnt counts to CLKS_PER_BIT−1, then samples Rx into shift[idx] (LSB first) and resets cnt.
  - After idx = 7 → STOP.
- STOP:
  - At cnt = CLKS_PER_BIT−1, sample Rx.
  - Rx = 1: on the next edge, out_data ← shift and out_valid ← 1. If out_valid was already 1 and rd_ack is not asserted that same cycle, set overrun; the new byte still overwrites. Go to IDLE.
  - Rx = 0: frame_err pulses one cycle, out_data and out_valid are unchanged, go to WAIT_IDLE.
- WAIT_IDLE (break / line held low): stay until Rx = 1, then go to IDLE. Prevents a false start on a held-low line.
- Latency from the start-edge at the pin to out_valid rising: 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles.
- rd_ack clears out_valid on the next edge.
- rd_ack and a new delivery in the same cycle: the delivery wins, so out_valid stays 1 with the new data, and no overrun is flagged.
- rd_ack while out_valid = 0 has no effect.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start bit immediately following the stop bit is caught.
- Reception tolerates ±4% rate mismatch against the transmitter.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - DEFAULT_CLKS_PER_BIT = 87.
  - DATA_BITS = 8.
  - The transmitter also uses this package.
- One sub-module, sync_2ff: generic single-bit 2-flop synchroniser with reset value parameter. It is reusable for other async inputs.

Test Plan:
1. CLKS_PER_BIT = 87, drive frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → out_valid = 1 with out_data = 0xA5 exactly 2+43+783+1 cycles after the start edge; frame_err = 0, rx_busy falls at mid-stop.
2. Loopback: the existing UART transmitter sends 0xAA then 0x55 back-to-back, consumer pulses rd_ack after each → two deliveries of 0xAA and 0x55 in order, overrun = 0.
3. Glitch: Rx low for 20 cycles then high → no state beyond START, rx_busy high ≤ 44 cycles then 0, out_valid stays 0.
4. Bad stop: frame 0x3C with stop bit 0, line then held low 300 cycles → one-cycle frame_err, out_valid/out_data unchanged, no new frame detected until the line returns high; then 0x81 received correctly.
5. Overrun: send 0x11 then 0x22 without rd_ack → out_data = 0x22, out_valid = 1, overrun = 1. Repeat with rd_ack coincident with the second delivery → overrun stays 0.
6. Reset at bit 4 of 0xF0 → all outputs 0 the cycle after; next clean frame 0x0F is received correctly.
